dmem_bus_if: RTL and testbench

//  Data-memory bus interface between the MEM stage and the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n)
//  of top. Registers one load/store request, runs the bus handshake, stalls the pipeline until ACKD_n,
//  and returns size-aligned, sign/zero-extended load data. STDOUT/EXIT stores are ordinary byte/word bus writes.

---
 rtl/dmem_bus_if_pkg.sv | 27 ++
 rtl/dmem_bus_if_if.sv | 30 +++
 rtl/dmem_bus_if_align.sv | 49 ++++
 rtl/dmem_bus_if.sv | 151 +++++++++++++++
 tb/tb_dmem_bus_if.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_bus_if_pkg.sv
// Shared types and constants for the data-memory bus interface.
package dmem_bus_if_pkg;

    // Bus transaction sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Access size codes, shared by req_size and the bus SIZE lines
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Memory-mapped I/O addresses used by program-level benches
    localparam logic [31:0] STDOUT_ADDR = 32'hf000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'hff00_0000;

    // Observation bundle: FSM state, timeout counter, DDT drive enable
    typedef struct packed {
        state_t      state;
        logic [7:0]  cnt;
        logic        ddt_oe;
    } dbg_t;

endpackage

// File: rtl/dmem_bus_if_if.sv
// External data-bus control lines. DDT stays a plain inout on the top so
// the tristate net resolves directly between the pad and the memory.
interface dmem_bus_if_if #(
    parameter int BIT_WIDTH = 32
);
    logic [BIT_WIDTH-1:0] DAD;
    logic                 MREQ;
    logic                 WRITE;
    logic [1:0]           SIZE;
    logic                 ACKD_n;

    // Handshake: the master holds MREQ/DAD/WRITE/SIZE stable while MREQ=1;
    // the slave completes the access by pulling ACKD_n low for one rising
    // edge, with read data valid on DDT at that same edge.
    modport master (
        output DAD,
        output MREQ,
        output WRITE,
        output SIZE,
        input  ACKD_n
    );

    modport slave (
        input  DAD,
        input  MREQ,
        input  WRITE,
        input  SIZE,
        output ACKD_n
    );
endinterface

// File: rtl/dmem_bus_if_align.sv
// Combinational data-path helpers: misalignment check on the incoming
// request, store lane placement, and load sign/zero extension.
module dmem_align
    import dmem_bus_if_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic [1:0]           req_size,
    input  logic [1:0]           addr_lo,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    input  logic [1:0]           ld_size,
    input  logic                 ld_signed,
    input  logic [BIT_WIDTH-1:0] ld_bus,
    output logic                 misaligned,
    output logic [BIT_WIDTH-1:0] st_data,
    output logic [BIT_WIDTH-1:0] ld_data
);

    // Words need addr[1:0]==0, halves addr[0]==0; bytes (and code 11) never fault
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SZ_WORD: misaligned = |addr_lo;
            SZ_HALF: misaligned = addr_lo[0];
            default: misaligned = 1'b0;
        endcase
    end

    // Store data goes out on the low lanes with the upper lanes zeroed
    always_comb begin
        st_data = req_wdata;
        case (req_size)
            SZ_WORD: st_data = req_wdata;
            SZ_HALF: st_data = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
            default: st_data = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
        endcase
    end

    // Load data is taken from the low lanes and extended to full width
    always_comb begin
        ld_data = ld_bus;
        case (ld_size)
            SZ_WORD: ld_data = ld_bus;
            SZ_HALF: ld_data = {{(BIT_WIDTH-16){ld_signed & ld_bus[15]}}, ld_bus[15:0]};
            default: ld_data = {{(BIT_WIDTH-8){ld_signed & ld_bus[7]}}, ld_bus[7:0]};
        endcase
    end

endmodule

// File: rtl/dmem_bus_if.sv
// Data-memory bus interface: accepts one MEM-stage load/store, runs the
// MREQ/ACKD_n handshake with a timeout, and returns extended load data.
module dmem_bus_if
    import dmem_bus_if_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 stall,
    output logic [BIT_WIDTH-1:0] rdata,
    output logic                 rdata_valid,
    output logic                 misalign,
    output logic                 bus_err,
    inout  wire  [BIT_WIDTH-1:0] DDT,
    dmem_bus_if_if.master        bus,
    output dbg_t                 dbg
);

    // Last counter value in BUSY before the access is abandoned
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q;
    logic [BIT_WIDTH-1:0]   dad_q;
    logic                   mreq_q;
    logic                   write_q;
    logic [1:0]             size_q;
    logic                   signed_q;
    logic [BIT_WIDTH-1:0]   wdata_q;
    logic [BIT_WIDTH-1:0]   rdata_q;
    logic                   misalign_q;
    logic                   bus_err_q;

    logic                   misaligned;
    logic [BIT_WIDTH-1:0]   st_data;
    logic [BIT_WIDTH-1:0]   ld_data;
    logic                   ack;
    logic                   timeout_hit;
    logic                   ddt_oe;

    dmem_align #(.BIT_WIDTH(BIT_WIDTH)) u_align (
        .req_size   (req_size),
        .addr_lo    (req_addr[1:0]),
        .req_wdata  (req_wdata),
        .ld_size    (size_q),
        .ld_signed  (signed_q),
        .ld_bus     (DDT),
        .misaligned (misaligned),
        .st_data    (st_data),
        .ld_data    (ld_data)
    );

    assign ack         = ~bus.ACKD_n;
    assign timeout_hit = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: an ack on the timeout edge still completes normally
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = misaligned ? ST_RESP : ST_BUSY;
            ST_BUSY: if (ack || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus registers, timeout counter, load data and response pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            dad_q      <= '0;
            mreq_q     <= 1'b0;
            write_q    <= 1'b0;
            size_q     <= SZ_WORD;
            signed_q   <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            dad_q    <= req_addr;
                            size_q   <= req_size;
                            write_q  <= req_we;
                            signed_q <= req_signed;
                            wdata_q  <= st_data;
                            mreq_q   <= 1'b1;
                            cnt_q    <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (ack) begin
                        if (!write_q) rdata_q <= ld_data;
                        mreq_q  <= 1'b0;
                        write_q <= 1'b0;
                    end else if (timeout_hit) begin
                        mreq_q    <= 1'b0;
                        write_q   <= 1'b0;
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // DDT is driven only while a write is on the bus; reset releases it at once
    assign ddt_oe = (state_q == ST_BUSY) && write_q;
    assign DDT    = ddt_oe ? wdata_q : 'z;

    assign bus.DAD   = dad_q;
    assign bus.MREQ  = mreq_q;
    assign bus.WRITE = write_q;
    assign bus.SIZE  = size_q;

    assign stall       = req_valid && (state_q != ST_RESP);
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == ST_RESP);
    assign misalign    = misalign_q;
    assign bus_err     = bus_err_q;

    assign dbg.state  = state_q;
    assign dbg.cnt    = cnt_q;
    assign dbg.ddt_oe = ddt_oe;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Bench for dmem_bus_if: directed spot cases followed by random accesses,
// all checked against an arithmetic reference model of the bus protocol.
module tb_dmem_bus_if;
    import dmem_bus_if_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;
    logic        bus_err;
    wire  [31:0] DDT;
    dbg_t        dbg;

    logic [31:0] mem_data;
    logic        mem_oe;
    assign DDT = mem_oe ? mem_data : 'z;

    dmem_bus_if_if #(.BIT_WIDTH(32)) bus ();

    dmem_bus_if #(.BIT_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .DDT         (DDT),
        .bus         (bus),
        .dbg         (dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] sz);
        if (sz == 2'd0) return 4;
        if (sz == 2'd1) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] model_store(input logic [1:0] sz, input logic [31:0] w);
        longint span;
        longint v;
        span = longint'(1) << (8 * size_bytes(sz));
        v = longint'(w) % span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sgn, input logic [31:0] w);
        longint span;
        longint v;
        int     nb;
        nb   = size_bytes(sz);
        span = longint'(1) << (8 * nb);
        v    = longint'(w) % span;
        if (sgn && nb < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Runs one access starting at a negedge with the DUT idle. ack_wait is
    // the number of BUSY edges the memory lets pass before acking;
    // ack_wait >= TIMEOUT means the memory never answers.
    task automatic access(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] bus_word, input int ack_wait);
        bit          mis;
        bit          timed_out;
        bit          done;
        int          stalls;
        int          exp_stalls;
        logic [31:0] exp_rd;

        mis       = (int'(addr % 32'(size_bytes(sz))) != 0);
        timed_out = !mis && (ack_wait >= TIMEOUT);
        if (mis || (we && !timed_out)) exp_rd = model_rdata;
        else if (timed_out)            exp_rd = 32'h0;
        else                           exp_rd = model_load(sz, sgn, bus_word);
        exp_q.push_back(exp_rd);
        model_rdata = exp_rd;
        exp_stalls  = mis ? 1 : (1 + (timed_out ? TIMEOUT : ack_wait + 1));

        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        #1;
        chk("idle_before_accept", 32'(dbg.state), 32'(ST_IDLE));
        stalls = stall ? 1 : 0;
        @(negedge clk);

        if (!mis) begin
            done = 1'b0;
            for (int k = 0; k < TIMEOUT + 2 && !done; k++) begin
                chk("busy_state", 32'(dbg.state), 32'(ST_BUSY));
                chk("busy_mreq", 32'(bus.MREQ), 32'd1);
                chk("busy_dad", bus.DAD, addr);
                chk("busy_size", 32'(bus.SIZE), 32'(sz));
                chk("busy_write", 32'(bus.WRITE), 32'(we));
                chk("busy_ddt_oe", 32'(dbg.ddt_oe), 32'(we));
                if (we) chk("busy_ddt", DDT, model_store(sz, wdata));
                if (stall) stalls++;
                // request lines wander while the latched copy is in use
                req_we     = 1'($urandom);
                req_size   = 2'($urandom);
                req_signed = 1'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
                bus.ACKD_n = (k == ack_wait) ? 1'b0 : 1'b1;
                mem_data   = bus_word;
                mem_oe     = !we;
                @(negedge clk);
                bus.ACKD_n = 1'b1;
                mem_oe     = 1'b0;
                done = (k == ack_wait) || (k == TIMEOUT - 1);
            end
            chk("busy_bound", 32'(done), 32'd1);
        end

        chk("resp_state", 32'(dbg.state), 32'(ST_RESP));
        chk("resp_valid", 32'(rdata_valid), 32'd1);
        chk("resp_stall", 32'(stall), 32'd0);
        chk("resp_misalign", 32'(misalign), 32'(mis));
        chk("resp_bus_err", 32'(bus_err), 32'(timed_out));
        chk("resp_mreq", 32'(bus.MREQ), 32'd0);
        chk("resp_ddt_oe", 32'(dbg.ddt_oe), 32'd0);
        chk("resp_rdata", rdata, exp_q.pop_front());
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));

        req_valid = 1'b0;
        @(negedge clk);
        chk("after_idle", 32'(dbg.state), 32'(ST_IDLE));
        chk("after_valid", 32'(rdata_valid), 32'd0);
        chk("after_pulses", 32'({misalign, bus_err}), 32'd0);
        chk("after_mreq", 32'(bus.MREQ), 32'd0);
        chk("after_rdata_hold", rdata, model_rdata);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_data   = '0;
        mem_oe     = 1'b0;
        bus.ACKD_n = 1'b1;
        model_rdata = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_state", 32'(dbg.state), 32'(ST_IDLE));
        chk("rst_mreq", 32'(bus.MREQ), 32'd0);
        chk("rst_write", 32'(bus.WRITE), 32'd0);
        chk("rst_size", 32'(bus.SIZE), 32'd0);
        chk("rst_dad", bus.DAD, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_pulses", 32'({rdata_valid, misalign, bus_err}), 32'd0);
        chk("rst_cnt", 32'(dbg.cnt), 32'd0);
        chk("rst_ddt_oe", 32'(dbg.ddt_oe), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // acks while idle are ignored
        bus.ACKD_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.ACKD_n = 1'b1;
        chk("idle_ack_state", 32'(dbg.state), 32'(ST_IDLE));
        chk("idle_ack_pulses", 32'({rdata_valid, misalign, bus_err, bus.MREQ}), 32'd0);

        // directed cases
        access(1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, 32'h1122_3344, 0);
        access(1'b0, SZ_BYTE, 1'b1, 32'h0000_0203, 32'h0, 32'h1234_5680, 1);
        access(1'b0, SZ_HALF, 1'b0, 32'h0000_0206, 32'h0, 32'hABCD_8001, 0);
        access(1'b1, SZ_BYTE, 1'b0, STDOUT_ADDR, 32'hDEAD_BE41, 32'h0, 2);
        access(1'b0, SZ_WORD, 1'b0, 32'h0000_0102, 32'h0, 32'h5555_5555, 0);
        access(1'b0, SZ_HALF, 1'b0, 32'h0000_0301, 32'h0, 32'h5555_5555, 0);
        access(1'b0, SZ_WORD, 1'b0, 32'h0000_0400, 32'h0, 32'h7777_7777, TIMEOUT);
        access(1'b0, SZ_WORD, 1'b0, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1);
        access(1'b1, SZ_WORD, 1'b0, EXIT_ADDR, 32'h0000_0001, 32'h0, 0);
        access(1'b0, 2'b11, 1'b1, 32'h0000_0507, 32'h0, 32'h0000_00FF, 0);
        access(1'b1, SZ_HALF, 1'b0, 32'h0000_0600, 32'h1234_5678, 32'h0, TIMEOUT + 1);

        // reset in the middle of a word store
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_WORD;
        req_addr  = 32'h0000_0800;
        req_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("mid_busy_mreq", 32'(bus.MREQ), 32'd1);
        chk("mid_busy_oe", 32'(dbg.ddt_oe), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_mreq", 32'(bus.MREQ), 32'd0);
        chk("mid_rst_oe", 32'(dbg.ddt_oe), 32'd0);
        chk("mid_rst_state", 32'(dbg.state), 32'(ST_IDLE));
        chk("mid_rst_valid", 32'(rdata_valid), 32'd0);
        model_rdata = 32'h0;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        access(1'b0, SZ_WORD, 1'b0, 32'h0000_0900, 32'h0, 32'h600D_600D, 1);

        // random accesses
        for (int n = 0; n < 40; n++) begin
            access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   $urandom, $urandom, $urandom, $urandom_range(0, TIMEOUT + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
